// File: rtl/pcie_tlp_pkg.sv
// TLP header encodings, field positions and decoder state/action types shared by
// the receive-side request path.
package pcie_tlp_pkg;

  localparam logic [1:0] FMT_3DW_ND = 2'b00;
  localparam logic [1:0] FMT_4DW_ND = 2'b01;
  localparam logic [1:0] FMT_3DW_D  = 2'b10;
  localparam logic [1:0] FMT_4DW_D  = 2'b11;
  localparam logic [4:0] TYPE_MEM   = 5'b00000;

  // DW0 field positions
  localparam int FMT_HI  = 30;
  localparam int FMT_LO  = 29;
  localparam int TYPE_HI = 28;
  localparam int TYPE_LO = 24;
  localparam int TC_HI   = 22;
  localparam int TC_LO   = 20;
  localparam int EP_BIT  = 14;
  localparam int ATTR_HI = 13;
  localparam int ATTR_LO = 12;
  localparam int LEN_HI  = 9;
  localparam int LEN_LO  = 0;

  // DW1 field positions, relative to DW1 bit 0
  localparam int REQ_ID_HI = 31;
  localparam int REQ_ID_LO = 16;
  localparam int TAG_HI    = 15;
  localparam int TAG_LO    = 8;
  localparam int LBE_HI    = 7;
  localparam int LBE_LO    = 4;
  localparam int FBE_HI    = 3;
  localparam int FBE_LO    = 0;

  localparam int TUSER_ERR_FWD = 1;
  localparam int TUSER_BAR_HI  = 8;
  localparam int TUSER_BAR_LO  = 2;

  typedef logic [2:0] state_t;
  localparam state_t ST_HDR0   = 3'd0;
  localparam state_t ST_HDR1   = 3'd1;
  localparam state_t ST_PAY    = 3'd2;
  localparam state_t ST_TAIL   = 3'd3;
  localparam state_t ST_RD_OUT = 3'd4;

  typedef enum logic [1:0] {
    ACT_DROP = 2'd0,
    ACT_WR   = 2'd1,
    ACT_RD   = 2'd2
  } action_t;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [2:0]  tc;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
  } tlp_hdr_t;

  // A header length of zero encodes the maximum of 1024 DWORDs.
  function automatic logic [10:0] len_to_dw(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/pcie_rx_req_decoder.sv
// Decodes MRd/MWr request TLPs from the 64-bit endpoint RX stream into a
// single-DWORD register write strobe and a read request handshake.
module pcie_rx_req_decoder
  import pcie_tlp_pkg::*;
#(
  parameter int DROP_CNT_W = 16
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [63:0]           m_axis_rx_tdata,
  input  logic [7:0]            m_axis_rx_tkeep,
  input  logic                  m_axis_rx_tlast,
  input  logic                  m_axis_rx_tvalid,
  output logic                  m_axis_rx_tready,
  input  logic [21:0]           m_axis_rx_tuser,
  output logic                  wr_en,
  output logic [63:0]           wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_be,
  output logic [6:0]            wr_bar,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [63:0]           rd_addr,
  output logic [10:0]           rd_len,
  output logic [15:0]           rd_req_id,
  output logic [7:0]            rd_tag,
  output logic [2:0]            rd_tc,
  output logic [1:0]            rd_attr,
  output logic [3:0]            rd_first_be,
  output logic [3:0]            rd_last_be,
  output logic [6:0]            rd_bar,
  output logic [DROP_CNT_W-1:0] drop_count
);

  state_t      state_q, state_d;
  tlp_hdr_t    hdr_q, hdr_in;
  logic [6:0]  bar_q;
  logic        err_q;
  logic [63:0] addr_q;
  logic [31:0] data_q;
  action_t     act_q;
  logic        tready_q;

  logic        beat, err_now, is_mwr, is_mrd, is_4dw;
  logic        finish, runt, drop_inc;
  logic [63:0] hdr1_addr, cur_addr;
  logic [31:0] cur_data;
  action_t     hdr1_act, cur_act, fin_act;

  logic unused_inputs;
  assign unused_inputs = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:9], m_axis_rx_tuser[0]};

  assign m_axis_rx_tready = tready_q;
  assign beat    = m_axis_rx_tvalid & tready_q;
  assign err_now = err_q | m_axis_rx_tuser[TUSER_ERR_FWD];

  assign hdr_in.fmt      = m_axis_rx_tdata[FMT_HI:FMT_LO];
  assign hdr_in.typ      = m_axis_rx_tdata[TYPE_HI:TYPE_LO];
  assign hdr_in.tc       = m_axis_rx_tdata[TC_HI:TC_LO];
  assign hdr_in.ep       = m_axis_rx_tdata[EP_BIT];
  assign hdr_in.attr     = m_axis_rx_tdata[ATTR_HI:ATTR_LO];
  assign hdr_in.len      = m_axis_rx_tdata[LEN_HI:LEN_LO];
  assign hdr_in.req_id   = m_axis_rx_tdata[32+REQ_ID_HI:32+REQ_ID_LO];
  assign hdr_in.tag      = m_axis_rx_tdata[32+TAG_HI:32+TAG_LO];
  assign hdr_in.last_be  = m_axis_rx_tdata[32+LBE_HI:32+LBE_LO];
  assign hdr_in.first_be = m_axis_rx_tdata[32+FBE_HI:32+FBE_LO];

  assign is_mwr = (hdr_q.typ == TYPE_MEM) &&  hdr_q.fmt[1];
  assign is_mrd = (hdr_q.typ == TYPE_MEM) && !hdr_q.fmt[1];
  assign is_4dw = hdr_q.fmt[0];

  // In a 4DW header DW2 carries the upper address half and DW3 the lower.
  assign hdr1_addr = is_4dw ? {m_axis_rx_tdata[31:0], m_axis_rx_tdata[63:34], 2'b00}
                            : {32'h0, m_axis_rx_tdata[31:2], 2'b00};

  assign hdr1_act = (is_mwr && hdr_q.len == 10'd1 && !hdr_q.ep) ? ACT_WR :
                    (is_mrd && !hdr_q.ep)                        ? ACT_RD : ACT_DROP;

  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    cur_addr = addr_q;
    cur_data = data_q;
    cur_act  = act_q;
    finish   = 1'b0;
    runt     = 1'b0;
    case (state_q)
      ST_HDR0: if (beat) begin
        if (m_axis_rx_tlast) runt    = 1'b1;
        else                 state_d = ST_HDR1;
      end
      ST_HDR1: if (beat) begin
        cur_addr = hdr1_addr;
        cur_data = m_axis_rx_tdata[63:32];
        // A 4DW write ending on its header beat carries no payload.
        cur_act  = (is_mwr && is_4dw) ? ACT_DROP : hdr1_act;
        if (m_axis_rx_tlast)       finish  = 1'b1;
        else if (is_mwr && is_4dw) state_d = ST_PAY;
        else                       state_d = ST_TAIL;
      end
      ST_PAY: if (beat) begin
        cur_data = m_axis_rx_tdata[31:0];
        if (m_axis_rx_tlast) finish  = 1'b1;
        else                 state_d = ST_TAIL;
      end
      ST_TAIL:   if (beat && m_axis_rx_tlast) finish = 1'b1;
      ST_RD_OUT: if (rd_ready) state_d = ST_HDR0;
      default:   state_d = ST_HDR0;
    endcase
    fin_act = err_now ? ACT_DROP : cur_act;
    if (finish) state_d = (fin_act == ACT_RD) ? ST_RD_OUT : ST_HDR0;
  end

  assign drop_inc = runt | (finish && fin_act == ACT_DROP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q    <= ST_HDR0;
      tready_q   <= 1'b0;
      wr_en      <= 1'b0;
      rd_valid   <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q  <= state_d;
      tready_q <= (state_d != ST_RD_OUT);
      wr_en    <= finish && (fin_act == ACT_WR);
      if (finish && fin_act == ACT_RD)        rd_valid <= 1'b1;
      else if (state_q == ST_RD_OUT && rd_ready) rd_valid <= 1'b0;
      if (drop_inc && drop_count != {DROP_CNT_W{1'b1}})
        drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      hdr_q       <= '0;
      bar_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      act_q       <= ACT_DROP;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_be       <= '0;
      wr_bar      <= '0;
      rd_addr     <= '0;
      rd_len      <= '0;
      rd_req_id   <= '0;
      rd_tag      <= '0;
      rd_tc       <= '0;
      rd_attr     <= '0;
      rd_first_be <= '0;
      rd_last_be  <= '0;
      rd_bar      <= '0;
    end else begin
      if (beat) begin
        if (state_q == ST_HDR0) begin
          hdr_q <= hdr_in;
          bar_q <= m_axis_rx_tuser[TUSER_BAR_HI:TUSER_BAR_LO];
          err_q <= m_axis_rx_tuser[TUSER_ERR_FWD];
        end else begin
          err_q <= err_now;
        end
        if (state_q == ST_HDR1) begin
          addr_q <= hdr1_addr;
          data_q <= m_axis_rx_tdata[63:32];
          act_q  <= hdr1_act;
        end
        if (state_q == ST_PAY) data_q <= m_axis_rx_tdata[31:0];
      end
      if (finish && fin_act == ACT_WR) begin
        wr_addr <= cur_addr;
        wr_data <= cur_data;
        wr_be   <= hdr_q.first_be;
        wr_bar  <= bar_q;
      end
      if (finish && fin_act == ACT_RD) begin
        rd_addr     <= cur_addr;
        rd_len      <= len_to_dw(hdr_q.len);
        rd_req_id   <= hdr_q.req_id;
        rd_tag      <= hdr_q.tag;
        rd_tc       <= hdr_q.tc;
        rd_attr     <= hdr_q.attr;
        rd_first_be <= hdr_q.first_be;
        rd_last_be  <= hdr_q.last_be;
        rd_bar      <= bar_q;
      end
    end
  end

endmodule

// File: tb/tb_pcie_rx_req_decoder.sv
// Directed bench for pcie_rx_req_decoder; a second 4-bit-counter instance on the
// same stream exercises drop counter saturation.
module tb_pcie_rx_req_decoder;

  logic        user_clk = 1'b0;
  logic        user_reset = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = 8'hFF;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic [21:0] tuser = '0;
  logic        rd_ready = 1'b0;

  logic        tready, wr_en, rd_valid;
  logic [63:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be, rd_first_be, rd_last_be;
  logic [6:0]  wr_bar, rd_bar;
  logic [10:0] rd_len;
  logic [15:0] rd_req_id, drop_count;
  logic [7:0]  rd_tag;
  logic [2:0]  rd_tc;
  logic [1:0]  rd_attr;

  logic        s_tready, s_wr_en, s_rd_valid;
  logic [63:0] s_wr_addr, s_rd_addr;
  logic [31:0] s_wr_data;
  logic [3:0]  s_wr_be, s_rd_first_be, s_rd_last_be;
  logic [6:0]  s_wr_bar, s_rd_bar;
  logic [10:0] s_rd_len;
  logic [15:0] s_rd_req_id;
  logic [3:0]  s_drop_count;
  logic [7:0]  s_rd_tag;
  logic [2:0]  s_rd_tc;
  logic [1:0]  s_rd_attr;

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;
  int rd_cycles = 0;

  localparam logic [21:0] U_BAR0 = 22'h4;
  localparam logic [21:0] U_BAR1 = 22'h8;
  localparam logic [21:0] U_ERR  = 22'h2;

  always #5 user_clk = ~user_clk;

  pcie_rx_req_decoder #(.DROP_CNT_W(16)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep), .m_axis_rx_tlast(tlast),
    .m_axis_rx_tvalid(tvalid), .m_axis_rx_tready(tready), .m_axis_rx_tuser(tuser),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_bar(wr_bar),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_req_id(rd_req_id), .rd_tag(rd_tag), .rd_tc(rd_tc), .rd_attr(rd_attr),
    .rd_first_be(rd_first_be), .rd_last_be(rd_last_be), .rd_bar(rd_bar),
    .drop_count(drop_count)
  );

  pcie_rx_req_decoder #(.DROP_CNT_W(4)) dut_sat (
    .user_clk(user_clk), .user_reset(user_reset),
    .m_axis_rx_tdata(tdata), .m_axis_rx_tkeep(tkeep), .m_axis_rx_tlast(tlast),
    .m_axis_rx_tvalid(tvalid), .m_axis_rx_tready(s_tready), .m_axis_rx_tuser(tuser),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_be(s_wr_be), .wr_bar(s_wr_bar),
    .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_addr(s_rd_addr), .rd_len(s_rd_len),
    .rd_req_id(s_rd_req_id), .rd_tag(s_rd_tag), .rd_tc(s_rd_tc), .rd_attr(s_rd_attr),
    .rd_first_be(s_rd_first_be), .rd_last_be(s_rd_last_be), .rd_bar(s_rd_bar),
    .drop_count(s_drop_count)
  );

  always @(posedge user_clk) begin
    if (wr_en)    wr_pulses <= wr_pulses + 1;
    if (rd_valid) rd_cycles <= rd_cycles + 1;
  end

  function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                      input logic [2:0] tc, input logic ep,
                                      input logic [1:0] attr, input logic [9:0] len,
                                      input logic [15:0] rid, input logic [7:0] tag,
                                      input logic [3:0] lbe, input logic [3:0] fbe);
    logic [31:0] dw0;
    dw0 = '0;
    dw0[30:29] = fmt;
    dw0[28:24] = typ;
    dw0[22:20] = tc;
    dw0[14]    = ep;
    dw0[13:12] = attr;
    dw0[9:0]   = len;
    return {rid, tag, lbe, fbe, dw0};
  endfunction

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic [21:0] u);
    int n = 0;
    tdata = d; tlast = last; tuser = u; tvalid = 1'b1;
    while (tready !== 1'b1 && n < 50) begin
      @(posedge user_clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL beat_accept_timeout got tready=%b exp 1", tready);
    end
    @(posedge user_clk); #1;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0; tlast = 1'b0; tuser = '0;
    repeat (n) begin @(posedge user_clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge user_clk); #1;
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL rst_tready got %b exp 0", tready); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en got %b exp 0", wr_en); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL rst_drop got %h exp 0", drop_count); end
    tests++; if (wr_addr !== 64'h0 || rd_len !== 11'h0) begin fails++; $display("FAIL rst_fields got %h/%h exp 0/0", wr_addr, rd_len); end
    user_reset = 1'b0;
    @(posedge user_clk); #1;
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL rst_tready_rise got %b exp 1", tready); end
  endtask

  task automatic test_mwr_3dw();
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b0, U_BAR0);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mwr3_early got %b exp 0", wr_en); end
    send_beat({32'hDEADBEEF, 32'h0000_1004}, 1'b1, U_BAR0);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mwr3_wr_en got %b exp 1", wr_en); end
    tests++; if (wr_addr !== 64'h1004) begin fails++; $display("FAIL mwr3_addr got %h exp 1004", wr_addr); end
    tests++; if (wr_data !== 32'hDEADBEEF) begin fails++; $display("FAIL mwr3_data got %h exp deadbeef", wr_data); end
    tests++; if (wr_be !== 4'hF || wr_bar !== 7'b0000001) begin fails++; $display("FAIL mwr3_be_bar got %h/%b exp f/0000001", wr_be, wr_bar); end
    tests++; if (drop_count !== 16'h0) begin fails++; $display("FAIL mwr3_drop got %h exp 0", drop_count); end
    idle(1);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mwr3_one_cycle got %b exp 0", wr_en); end
  endtask

  task automatic test_mwr_4dw();
    logic [63:0] h;
    send_beat(hdr(2'b11, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'h3), 1'b0, U_BAR0);
    idle(2);
    send_beat({32'h2345_6780, 32'h0000_0001}, 1'b0, U_BAR0);
    idle(1);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL mwr4_early got %b exp 0", wr_en); end
    send_beat({32'h0, 32'h0BAD_F00D}, 1'b1, U_BAR0);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mwr4_wr_en got %b exp 1", wr_en); end
    tests++; if (wr_addr !== 64'h1_2345_6780) begin fails++; $display("FAIL mwr4_addr got %h exp 123456780", wr_addr); end
    tests++; if (wr_data !== 32'h0BAD_F00D || wr_be !== 4'h3) begin fails++; $display("FAIL mwr4_data_be got %h/%h exp 0badf00d/3", wr_data, wr_be); end
    idle(1);
    h = hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF);
    h[15] = 1'b1;
    send_beat(h, 1'b0, U_BAR1);
    send_beat({32'h0BAD_F00D, 32'h2345_6780}, 1'b0, U_BAR1);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL td_early got %b exp 0", wr_en); end
    send_beat({32'h0, 32'h1234_5678}, 1'b1, U_BAR1);
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL td_wr_en got %b exp 1", wr_en); end
    tests++; if (wr_addr !== 64'h2345_6780 || wr_data !== 32'h0BAD_F00D) begin fails++; $display("FAIL td_fields got %h/%h exp 23456780/0badf00d", wr_addr, wr_data); end
    tests++; if (wr_bar !== 7'b0000010) begin fails++; $display("FAIL td_bar got %b exp 0000010", wr_bar); end
    idle(1);
  endtask

  task automatic test_mrd();
    rd_ready = 1'b0;
    send_beat(hdr(2'b00, 5'd0, 3'd3, 1'b0, 2'b10, 10'd0, 16'h0100, 8'h2A, 4'hF, 4'hF), 1'b0, U_BAR1);
    send_beat({32'h0, 32'h0000_8000}, 1'b1, U_BAR1);
    tvalid = 1'b0; tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (rd_valid !== 1'b1 || tready !== 1'b0) begin fails++; $display("FAIL mrd_hold%0d got valid=%b tready=%b exp 1/0", i, rd_valid, tready); end
      tests++; if (rd_len !== 11'd1024 || rd_addr !== 64'h8000) begin fails++; $display("FAIL mrd_len_addr%0d got %0d/%h exp 1024/8000", i, rd_len, rd_addr); end
      tests++; if (rd_tag !== 8'h2A || rd_req_id !== 16'h0100) begin fails++; $display("FAIL mrd_id%0d got %h/%h exp 2a/0100", i, rd_tag, rd_req_id); end
      @(posedge user_clk); #1;
    end
    tests++; if (rd_tc !== 3'd3 || rd_attr !== 2'b10 || rd_bar !== 7'b0000010) begin fails++; $display("FAIL mrd_tc_attr_bar got %h/%h/%b exp 3/2/0000010", rd_tc, rd_attr, rd_bar); end
    tests++; if (rd_first_be !== 4'hF || rd_last_be !== 4'hF) begin fails++; $display("FAIL mrd_be got %h/%h exp f/f", rd_first_be, rd_last_be); end
    rd_ready = 1'b1;
    @(posedge user_clk); #1;
    rd_ready = 1'b0;
    tests++; if (rd_valid !== 1'b0 || tready !== 1'b1) begin fails++; $display("FAIL mrd_release got valid=%b tready=%b exp 0/1", rd_valid, tready); end
    rd_ready = 1'b1;
    send_beat(hdr(2'b01, 5'd0, 3'd0, 1'b0, 2'd0, 10'd4, 16'hBEEF, 8'h11, 4'hF, 4'hF), 1'b0, U_BAR0);
    send_beat({32'hCAFE_0000, 32'h0000_00AB}, 1'b1, U_BAR0);
    tvalid = 1'b0; tlast = 1'b0;
    tests++; if (rd_valid !== 1'b1 || rd_addr !== 64'h0000_00AB_CAFE_0000) begin fails++; $display("FAIL mrd4_addr got %b/%h exp 1/000000abcafe0000", rd_valid, rd_addr); end
    tests++; if (rd_len !== 11'd4 || rd_req_id !== 16'hBEEF || rd_bar !== 7'b0000001) begin fails++; $display("FAIL mrd4_fields got %0d/%h/%b exp 4/beef/0000001", rd_len, rd_req_id, rd_bar); end
    @(posedge user_clk); #1;
    tests++; if (rd_valid !== 1'b0 || tready !== 1'b1) begin fails++; $display("FAIL mrd4_release got valid=%b tready=%b exp 0/1", rd_valid, tready); end
    rd_ready = 1'b0;
  endtask

  task automatic test_drops();
    int wr0, rd0;
    idle(1);
    wr0 = wr_pulses; rd0 = rd_cycles;
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd2, 16'h0, 8'h0, 4'hF, 4'hF), 1'b0, U_BAR0);
    send_beat({32'h1111_1111, 32'h0000_0040}, 1'b0, U_BAR0);
    send_beat({32'h0, 32'h2222_2222}, 1'b1, U_BAR0);
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b1, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b0, U_BAR0);
    send_beat({32'h3333_3333, 32'h0000_0044}, 1'b1, U_BAR0);
    send_beat(hdr(2'b01, 5'b10000, 3'd0, 1'b0, 2'd0, 10'd0, 16'h0, 8'h0, 4'h0, 4'h0), 1'b0, 22'h0);
    send_beat(64'h0, 1'b1, 22'h0);
    idle(2);
    tests++; if (drop_count !== 16'd3) begin fails++; $display("FAIL drop_three got %0d exp 3", drop_count); end
    tests++; if (wr_pulses !== wr0 || rd_cycles !== rd0) begin fails++; $display("FAIL drop_no_output got wr=%0d rd=%0d exp 0/0", wr_pulses - wr0, rd_cycles - rd0); end
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b0, U_BAR0);
    send_beat({32'h4444_4444, 32'h0000_0048}, 1'b1, U_BAR0 | U_ERR);
    send_beat(hdr(2'b00, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h1, 4'h0, 4'hF), 1'b0, U_BAR0 | U_ERR);
    send_beat({32'h0, 32'h0000_004C}, 1'b1, U_BAR0);
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b1, U_BAR0);
    idle(2);
    tests++; if (drop_count !== 16'd6) begin fails++; $display("FAIL drop_errfwd_runt got %0d exp 6", drop_count); end
    tests++; if (wr_pulses !== wr0 || rd_cycles !== rd0) begin fails++; $display("FAIL drop_errfwd_output got wr=%0d rd=%0d exp 0/0", wr_pulses - wr0, rd_cycles - rd0); end
    tests++; if (s_drop_count !== 4'd6) begin fails++; $display("FAIL drop_small got %0d exp 6", s_drop_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++)
      send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b1, U_BAR0);
    idle(1);
    tests++; if (s_drop_count !== 4'hF || drop_count !== 16'd15) begin fails++; $display("FAIL sat_reach got %h/%0d exp f/15", s_drop_count, drop_count); end
    for (int i = 0; i < 3; i++)
      send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b1, U_BAR0);
    idle(1);
    tests++; if (s_drop_count !== 4'hF) begin fails++; $display("FAIL sat_hold got %h exp f", s_drop_count); end
    tests++; if (drop_count !== 16'd18) begin fails++; $display("FAIL sat_wide got %0d exp 18", drop_count); end
  endtask

  task automatic test_back_to_back();
    int wr0;
    longint t0;
    wr0 = wr_pulses;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b0, U_BAR0);
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL b2b_gap%0d got %b exp 0", i, wr_en); end
      send_beat({32'hA5A5_0000 + 32'(i), 32'h0000_0100 + 32'(4 * i)}, 1'b1, U_BAR0);
      tests++; if (wr_en !== 1'b1 || wr_addr !== 64'h100 + 64'(4 * i) || wr_data !== 32'hA5A5_0000 + 32'(i))
        begin fails++; $display("FAIL b2b_wr%0d got %b/%h/%h exp 1/%h/%h", i, wr_en, wr_addr, wr_data, 64'h100 + 64'(4 * i), 32'hA5A5_0000 + 32'(i)); end
    end
    tests++; if ($time - t0 != 80) begin fails++; $display("FAIL b2b_throughput got %0d exp 80", $time - t0); end
    idle(1);
    tests++; if (wr_pulses - wr0 != 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", wr_pulses - wr0); end
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_pulses;
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hF), 1'b0, U_BAR0);
    tvalid = 1'b0;
    #2 user_reset = 1'b1;
    #1;
    tests++; if (tready !== 1'b0 || wr_en !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl got %b/%b/%b exp 0/0/0", tready, wr_en, rd_valid); end
    tests++; if (drop_count !== 16'h0 || wr_addr !== 64'h0 || wr_data !== 32'h0) begin fails++; $display("FAIL rstmid_regs got %h/%h/%h exp 0/0/0", drop_count, wr_addr, wr_data); end
    @(posedge user_clk); #1;
    user_reset = 1'b0;
    @(posedge user_clk); #1;
    send_beat(hdr(2'b10, 5'd0, 3'd0, 1'b0, 2'd0, 10'd1, 16'h0, 8'h0, 4'h0, 4'hC), 1'b0, U_BAR1);
    send_beat({32'h5555_AAAA, 32'h0000_2000}, 1'b1, U_BAR1);
    tests++; if (wr_en !== 1'b1 || wr_addr !== 64'h2000 || wr_data !== 32'h5555_AAAA || wr_be !== 4'hC)
      begin fails++; $display("FAIL rstmid_next got %b/%h/%h/%h exp 1/2000/5555aaaa/c", wr_en, wr_addr, wr_data, wr_be); end
    idle(2);
    tests++; if (wr_pulses - wr0 != 1 || drop_count !== 16'h0) begin fails++; $display("FAIL rstmid_counts got wr=%0d drop=%0d exp 1/0", wr_pulses - wr0, drop_count); end
  endtask

  initial begin
    test_reset();
    test_mwr_3dw();
    test_mwr_4dw();
    test_mrd();
    test_drops();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
